// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : fetch, load/store and RAM-side signal bundle for mem_arbiter
// Revision 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic [DATA_W-1:0] ram_A;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic              ram_rw;
  logic [DATA_W-1:0] ram_Q;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_Q,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           ram_A, ram_addr, ram_en, ram_rw, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_Q,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           ram_A, ram_addr, ram_en, ram_rw, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch vs load/store arbiter sequencing one RAM access at a time
// Revision 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int c_WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int c_SCNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  localparam logic [c_WCNT_W-1:0] c_WAIT_LAST  = c_WCNT_W'(WAIT_CYCLES - 1);
  localparam logic [c_WCNT_W-1:0] c_WAIT_ONE   = c_WCNT_W'(1);
  localparam logic [c_SCNT_W-1:0] c_STARVE_MAX = c_SCNT_W'(STARVE_LIMIT);
  localparam logic [c_SCNT_W-1:0] c_STARVE_ONE = c_SCNT_W'(1);

  logic [1:0]          r_state, w_next_state;
  logic [c_WCNT_W-1:0] r_wait_cnt;
  logic [c_SCNT_W-1:0] r_starve_cnt;
  logic                r_sel_if;

  logic              r_if_gnt, r_if_rvalid, r_ls_gnt, r_ls_rvalid;
  logic [DATA_W-1:0] r_if_rdata, r_ls_rdata, r_ram_A;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_en, r_ram_rw, r_busy;

  logic              w_if_gnt, w_if_rvalid, w_ls_gnt, w_ls_rvalid;
  logic [DATA_W-1:0] w_if_rdata, w_ls_rdata, w_ram_A;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_en, w_ram_rw, w_busy;

  logic w_start, w_pick_if, w_last;

  assign w_start   = (r_state == c_IDLE) && (bus.if_req || bus.ls_req);
  assign w_pick_if = bus.if_req && (!bus.ls_req || (r_starve_cnt == c_STARVE_MAX));
  assign w_last    = (r_state == c_ACCESS) && (r_wait_cnt == c_WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_sel_if     <= 1'b0;
      r_if_gnt     <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_ls_gnt     <= 1'b0;
      r_ls_rvalid  <= 1'b0;
      r_ls_rdata   <= '0;
      r_ram_A      <= '0;
      r_ram_addr   <= '0;
      r_ram_en     <= 1'b0;
      r_ram_rw     <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= (r_state == c_ACCESS && !w_last) ? r_wait_cnt + c_WAIT_ONE : '0;
      if (w_start) begin
        r_sel_if <= w_pick_if;
        // Count only data wins that left a fetch waiting; saturate at the limit
        if (w_pick_if)
          r_starve_cnt <= '0;
        else if (bus.if_req && (r_starve_cnt != c_STARVE_MAX))
          r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
      end
      r_if_gnt    <= w_if_gnt;
      r_if_rvalid <= w_if_rvalid;
      r_if_rdata  <= w_if_rdata;
      r_ls_gnt    <= w_ls_gnt;
      r_ls_rvalid <= w_ls_rvalid;
      r_ls_rdata  <= w_ls_rdata;
      r_ram_A     <= w_ram_A;
      r_ram_addr  <= w_ram_addr;
      r_ram_en    <= w_ram_en;
      r_ram_rw    <= w_ram_rw;
      r_busy      <= w_busy;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (w_start) w_next_state = c_ACCESS;
      c_ACCESS: if (w_last)  w_next_state = c_RESP;
      c_RESP:   w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // Computes the value every output register takes at the coming edge
  always_comb begin
    w_if_gnt    = 1'b0;
    w_ls_gnt    = 1'b0;
    w_if_rvalid = 1'b0;
    w_ls_rvalid = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_ls_rdata  = r_ls_rdata;
    w_ram_addr  = r_ram_addr;
    w_ram_A     = r_ram_A;
    w_ram_rw    = r_ram_rw;
    w_ram_en    = (w_next_state == c_ACCESS);
    w_busy      = (w_next_state != c_IDLE);
    if (w_start) begin
      w_if_gnt   = w_pick_if;
      w_ls_gnt   = !w_pick_if;
      w_ram_addr = w_pick_if ? bus.if_addr : bus.ls_addr;
      w_ram_rw   = w_pick_if || !bus.ls_we;
      w_ram_A    = (!w_pick_if && bus.ls_we) ? bus.ls_wdata : '0;
    end
    if (w_last) begin
      if (r_sel_if)
        w_if_rdata = bus.ram_Q;
      else
        w_ls_rdata = r_ram_rw ? bus.ram_Q : '0;
      w_if_rvalid = r_sel_if;
      w_ls_rvalid = !r_sel_if;
      w_ram_rw    = 1'b1;
      w_ram_A     = '0;
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_gnt    = r_ls_gnt;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.ram_A     = r_ram_A;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_rw    = r_ram_rw;
  assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed bench for mem_arbiter (WAIT_CYCLES 1 and 3 instances)
// Revision 1.0
// ============================================================================
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst1, rst3;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3.slave)
  );

  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];

  assign bus1.ram_Q = (bus1.ram_en && bus1.ram_rw) ? mem1[bus1.ram_addr[7:0]] : 16'h0000;
  assign bus3.ram_Q = (bus3.ram_en && bus3.ram_rw) ? mem3[bus3.ram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!rst1 && bus1.ram_en && !bus1.ram_rw) mem1[bus1.ram_addr[7:0]] <= bus1.ram_A;
    if (!rst3 && bus3.ram_en && !bus3.ram_rw) mem3[bus3.ram_addr[7:0]] <= bus3.ram_A;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] order;
    int         n_gnt;
    int         n_dbl;
    int         n_ifg;
    int         n_rv;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end
    mem1[4]    = 16'hABCD;
    mem3[8'h20] = 16'h1234;

    // Reset with both requests high
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.if_req = 1'b1; bus1.if_addr = 16'h0004;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0011; bus1.ls_wdata = 16'h0000;
    bus3.if_req = 1'b0; bus3.if_addr = 16'h0000;
    bus3.ls_req = 1'b0; bus3.ls_we = 1'b0; bus3.ls_addr = 16'h0000; bus3.ls_wdata = 16'h0000;
    tick();
    tick();
    chk("reset_gnt",    16'({bus1.if_gnt, bus1.ls_gnt}), 16'd0);
    chk("reset_rvalid", 16'({bus1.if_rvalid, bus1.ls_rvalid}), 16'd0);
    chk("reset_rdata",  bus1.if_rdata | bus1.ls_rdata, 16'h0000);
    chk("reset_ram_en", 16'(bus1.ram_en), 16'd0);
    chk("reset_ram_rw", 16'(bus1.ram_rw), 16'd1);
    chk("reset_ram_A",  bus1.ram_A, 16'h0000);
    chk("reset_addr",   bus1.ram_addr, 16'h0000);
    chk("reset_busy",   16'(bus1.busy), 16'd0);
    rst1 = 1'b0; rst3 = 1'b0;
    bus1.if_req = 1'b0; bus1.ls_req = 1'b0;
    tick();

    // Store 0x0F0F to 0x0011
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 16'h0011; bus1.ls_wdata = 16'h0F0F;
    tick();
    chk("wr_gnt",    16'({bus1.if_gnt, bus1.ls_gnt}), 16'd1);
    chk("wr_en",     16'(bus1.ram_en), 16'd1);
    chk("wr_rw",     16'(bus1.ram_rw), 16'd0);
    chk("wr_addr",   bus1.ram_addr, 16'h0011);
    chk("wr_A",      bus1.ram_A, 16'h0F0F);
    chk("wr_busy",   16'(bus1.busy), 16'd1);
    bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
    tick();
    chk("wr_rvalid", 16'(bus1.ls_rvalid), 16'd1);
    chk("wr_rdata",  bus1.ls_rdata, 16'h0000);
    chk("wr_resp_en", 16'(bus1.ram_en), 16'd0);
    chk("wr_resp_rw", 16'(bus1.ram_rw), 16'd1);
    chk("wr_resp_A",  bus1.ram_A, 16'h0000);
    chk("wr_commit",  mem1[8'h11], 16'h0F0F);
    tick();
    chk("wr_idle_rvalid", 16'(bus1.ls_rvalid), 16'd0);
    chk("wr_idle_busy",   16'(bus1.busy), 16'd0);

    // Load back from 0x0011
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0011;
    tick();
    chk("rd_gnt", 16'(bus1.ls_gnt), 16'd1);
    chk("rd_rw",  16'(bus1.ram_rw), 16'd1);
    chk("rd_rvalid_early", 16'(bus1.ls_rvalid), 16'd0);
    bus1.ls_req = 1'b0;
    tick();
    chk("rd_rvalid", 16'(bus1.ls_rvalid), 16'd1);
    chk("rd_rdata",  bus1.ls_rdata, 16'h0F0F);
    tick();

    // Fetch from 0x0004
    bus1.if_req = 1'b1; bus1.if_addr = 16'h0004;
    tick();
    chk("if_gnt",  16'({bus1.if_gnt, bus1.ls_gnt}), 16'd2);
    chk("if_addr", bus1.ram_addr, 16'h0004);
    chk("if_rw",   16'(bus1.ram_rw), 16'd1);
    bus1.if_req = 1'b0;
    tick();
    chk("if_rvalid",   16'(bus1.if_rvalid), 16'd1);
    chk("if_rdata",    bus1.if_rdata, 16'hABCD);
    chk("if_ls_quiet", 16'(bus1.ls_rvalid), 16'd0);
    chk("if_ls_rdata", bus1.ls_rdata, 16'h0F0F);
    tick();
    chk("if_rvalid_pulse", 16'(bus1.if_rvalid), 16'd0);
    chk("if_rdata_hold",   bus1.if_rdata, 16'hABCD);

    // Starvation: both requesters held high
    bus1.if_req = 1'b1; bus1.if_addr = 16'h0004;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0011;
    order = '0; n_gnt = 0; n_dbl = 0;
    for (int c = 0; c < 100 && n_gnt < 10; c++) begin
      tick();
      if (bus1.if_gnt && bus1.ls_gnt) n_dbl++;
      if (bus1.if_gnt || bus1.ls_gnt) begin
        order = {order[8:0], bus1.if_gnt};
        n_gnt++;
      end
    end
    chk("starve_count", 16'(n_gnt), 16'd10);
    chk("starve_order", 16'(order), 16'(10'b0000100001));
    chk("starve_double", 16'(n_dbl), 16'd0);
    bus1.if_req = 1'b0; bus1.ls_req = 1'b0;
    tick();
    tick();
    chk("starve_idle", 16'(bus1.busy), 16'd0);

    // Busy guard: data request waits out a whole fetch access
    bus1.if_req = 1'b1; bus1.if_addr = 16'h0004;
    n_ifg = 0;
    tick();
    n_ifg += int'(bus1.if_gnt);
    chk("guard_if_gnt", 16'(bus1.if_gnt), 16'd1);
    bus1.if_req = 1'b0;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 16'h0030; bus1.ls_wdata = 16'h5555;
    tick();
    n_ifg += int'(bus1.if_gnt);
    chk("guard_resp_ls_gnt", 16'(bus1.ls_gnt), 16'd0);
    chk("guard_resp_if_rv",  16'(bus1.if_rvalid), 16'd1);
    tick();
    n_ifg += int'(bus1.if_gnt);
    chk("guard_idle_ls_gnt", 16'(bus1.ls_gnt), 16'd0);
    chk("guard_idle_busy",   16'(bus1.busy), 16'd0);
    tick();
    n_ifg += int'(bus1.if_gnt);
    chk("guard_ls_gnt",  16'(bus1.ls_gnt), 16'd1);
    chk("guard_if_once", 16'(n_ifg), 16'd1);
    chk("guard_wr_rw",   16'(bus1.ram_rw), 16'd0);
    bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
    tick();
    chk("guard_wr_rvalid", 16'(bus1.ls_rvalid), 16'd1);
    chk("guard_wr_rdata",  bus1.ls_rdata, 16'h0000);
    chk("guard_if_keep",   bus1.if_rdata, 16'hABCD);
    tick();

    // WAIT_CYCLES=3: reset in the second ACCESS cycle of a read
    bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 16'h0020;
    tick();
    chk("w3_gnt", 16'(bus3.ls_gnt), 16'd1);
    chk("w3_en",  16'(bus3.ram_en), 16'd1);
    bus3.ls_req = 1'b0;
    tick();
    chk("w3_gnt_pulse", 16'(bus3.ls_gnt), 16'd0);
    chk("w3_en_a2",     16'(bus3.ram_en), 16'd1);
    rst3 = 1'b1;
    tick();
    chk("w3_rst_en",   16'(bus3.ram_en), 16'd0);
    chk("w3_rst_busy", 16'(bus3.busy), 16'd0);
    rst3 = 1'b0;
    n_rv = int'(bus3.ls_rvalid);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_rv += int'(bus3.ls_rvalid);
    end
    chk("w3_no_rvalid", 16'(n_rv), 16'd0);
    chk("w3_rdata_kept", bus3.ls_rdata, 16'h0000);

    // WAIT_CYCLES=3: full read latency
    bus3.ls_req = 1'b1; bus3.ls_addr = 16'h0020;
    tick();
    chk("w3r_gnt", 16'(bus3.ls_gnt), 16'd1);
    bus3.ls_req = 1'b0;
    tick();
    chk("w3r_en_a2", 16'({bus3.ram_en, bus3.ls_rvalid}), 16'd2);
    tick();
    chk("w3r_en_a3", 16'({bus3.ram_en, bus3.ls_rvalid}), 16'd2);
    tick();
    chk("w3r_rvalid", 16'({bus3.ram_en, bus3.ls_rvalid}), 16'd1);
    chk("w3r_rdata",  bus3.ls_rdata, 16'h1234);
    tick();
    chk("w3r_idle", 16'({bus3.busy, bus3.ls_rvalid}), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
